hevc_mac_accumulate: RTL and testbench



---
 rtl/hevc_mac_accumulate_if.sv | 36 +++
 rtl/hevc_mac_accumulate.sv | 132 +++++++++++++
 tb/tb_hevc_mac_accumulate.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/hevc_mac_accumulate_if.sv
// FIFO bank interfaces used by hevc_mac_accumulate.
//
// read_interface : a bank of FLUX first-word-fall-through FIFOs feeding an actor.
//   dout[i]  word at the head of FIFO i, {tag, data}; valid while empty[i] == 0
//   empty[i] FIFO i holds no word
//   read[i]  pop FIFO i at the next rising edge
// write_interface : a bank of FLUX FIFOs fed by an actor through one shared write port.
//   din      {tag, data}; the tag field selects the destination FIFO
//   full[i]  FIFO i cannot accept a word
//   write    push din at the next rising edge
//
// Modports: actor = the dataflow actor side, fifo = the FIFO bank side.

interface read_interface #(
  parameter int unsigned FLUX       = 2,
  parameter int unsigned DATA_WIDTH = 17
);
  logic [FLUX-1:0][DATA_WIDTH-1:0] dout;
  logic [FLUX-1:0]                 empty;
  logic [FLUX-1:0]                 read;

  modport actor (input dout, input empty, output read);
  modport fifo  (output dout, output empty, input read);
endinterface

interface write_interface #(
  parameter int unsigned FLUX       = 2,
  parameter int unsigned DATA_WIDTH = 28
);
  logic [DATA_WIDTH-1:0] din;
  logic [FLUX-1:0]       full;
  logic                  write;

  modport actor (output din, input full, output write);
  modport fifo  (input din, output full, input write);
endinterface

// File: rtl/hevc_mac_accumulate.sv
// Multi-flux multiply-accumulate actor feeding the HEVC 12-bit rounding shifter.
//
// For one flux at a time it pops TAPS (residue, coefficient) pairs, sums their signed
// products on top of a rounding offset of 1 << (SHIFT_NUM-1), and emits one tagged sum so
// that the downstream arithmetic shift by SHIFT_NUM rounds to nearest.
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   read_port_in_src    residue FIFO bank, dout[i] = {tag, signed residue}
//   read_port_in_coef   coefficient FIFO bank, dout[i] = {tag, signed coefficient}
//   write_port_out_pel  output FIFO bank, din = {tag, signed sum}

module hevc_mac_accumulate #(
  parameter int unsigned FLUX            = 2,
  parameter int unsigned TAG_WIDTH       = (FLUX > 1) ? $clog2(FLUX) : 1,
  parameter int unsigned TAPS            = 4,
  parameter int unsigned SRC_DATA_WIDTH  = 16,
  parameter int unsigned COEF_DATA_WIDTH = 8,
  parameter int unsigned OUT_DATA_WIDTH  = 27,
  parameter int unsigned SHIFT_NUM       = 12
) (
  input  logic    clk,
  input  logic    rst_n,
  read_interface.actor  read_port_in_src,
  read_interface.actor  read_port_in_coef,
  write_interface.actor write_port_out_pel
);

  localparam int unsigned CntWidth  = (TAPS > 2) ? $clog2(TAPS) : 1;
  localparam int unsigned ProdWidth = SRC_DATA_WIDTH + COEF_DATA_WIDTH;
  localparam logic [OUT_DATA_WIDTH-1:0] Round = OUT_DATA_WIDTH'(1) << (SHIFT_NUM - 1);
  localparam logic [CntWidth-1:0]       LastCnt = CntWidth'(TAPS - 1);

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  state_e                      state_q, state_d;
  logic [TAG_WIDTH-1:0]        tag_q, tag_d;
  logic [CntWidth-1:0]         cnt_q, cnt_d;
  logic [OUT_DATA_WIDTH-1:0]   acc_q, acc_d;

  logic [FLUX-1:0]             pair_ready;
  logic                        any_ready;
  logic [TAG_WIDTH-1:0]        tag_sel;
  logic [TAG_WIDTH+SRC_DATA_WIDTH-1:0]  src_word;
  logic [TAG_WIDTH+COEF_DATA_WIDTH-1:0] coef_word;
  logic signed [SRC_DATA_WIDTH-1:0]     src_data;
  logic signed [COEF_DATA_WIDTH-1:0]    coef_data;
  logic signed [ProdWidth-1:0]          prod;
  logic signed [OUT_DATA_WIDTH-1:0]     prod_ext;
  logic                        pop;

  // A flux is eligible only when both operands of its next pair are present.
  assign pair_ready = ~read_port_in_src.empty & ~read_port_in_coef.empty;
  assign any_ready  = |pair_ready;

  // Fixed priority: the lowest ready index wins.
  always_comb begin
    tag_sel = '0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (pair_ready[i]) tag_sel = TAG_WIDTH'(i);
    end
  end

  // The tag fields of the input words are not needed: the FIFO index already names the flux.
  assign src_word  = read_port_in_src.dout[tag_q];
  assign coef_word = read_port_in_coef.dout[tag_q];
  assign src_data  = src_word[SRC_DATA_WIDTH-1:0];
  assign coef_data = coef_word[COEF_DATA_WIDTH-1:0];
  assign prod      = src_data * coef_data;
  assign prod_ext  = OUT_DATA_WIDTH'(prod);

  logic unused_dout;
  assign unused_dout = ^{read_port_in_src.dout, read_port_in_coef.dout};

  assign pop = (state_q == StAcc) && pair_ready[tag_q];

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;

    read_port_in_src.read    = '0;
    read_port_in_coef.read   = '0;
    write_port_out_pel.write = 1'b0;
    write_port_out_pel.din   = {tag_q, acc_q};

    unique case (state_q)
      StIdle: begin
        // Selection cycle only; popping starts in StAcc.
        if (any_ready) begin
          tag_d   = tag_sel;
          cnt_d   = '0;
          acc_d   = Round;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (pop) begin
          read_port_in_src.read[tag_q]  = 1'b1;
          read_port_in_coef.read[tag_q] = 1'b1;
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q + CntWidth'(1);
          if (cnt_q == LastCnt) state_d = StOut;
        end
      end
      StOut: begin
        if (!write_port_out_pel.full[tag_q]) begin
          write_port_out_pel.write = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tag_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_hevc_mac_accumulate.sv
// Directed bench for hevc_mac_accumulate: behavioural FWFT FIFOs on both read banks,
// a logged output port, and hand-computed expected sums.

module tb_hevc_mac_accumulate;

  localparam int unsigned TW = 1;
  localparam int unsigned SW = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned OW = 27;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] full_r;

  read_interface  #(.FLUX(2), .DATA_WIDTH(TW + SW)) src_if ();
  read_interface  #(.FLUX(2), .DATA_WIDTH(TW + CW)) coef_if ();
  write_interface #(.FLUX(2), .DATA_WIDTH(TW + OW)) pel_if ();

  hevc_mac_accumulate dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .read_port_in_src   (src_if),
    .read_port_in_coef  (coef_if),
    .write_port_out_pel (pel_if)
  );

  always #5 clk = ~clk;

  // FIFO storage: pointers grow without bound, storage is indexed modulo 16.
  logic [SW-1:0] src_mem  [2][16];
  logic [CW-1:0] coef_mem [2][16];
  logic [31:0]   src_rd [2] = '{default: 0};
  logic [31:0]   coef_rd[2] = '{default: 0};
  logic [31:0]   src_wr [2] = '{default: 0};
  logic [31:0]   coef_wr[2] = '{default: 0};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      src_if.empty[i]  = (src_rd[i] == src_wr[i]);
      coef_if.empty[i] = (coef_rd[i] == coef_wr[i]);
      src_if.dout[i]   = {TW'(i), src_mem[i][src_rd[i][3:0]]};
      coef_if.dout[i]  = {TW'(i), coef_mem[i][coef_rd[i][3:0]]};
    end
  end

  assign pel_if.full = full_r;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (src_if.read[i])  src_rd[i]  <= src_rd[i] + 1;
      if (coef_if.read[i]) coef_rd[i] <= coef_rd[i] + 1;
    end
  end

  // Monitor: edge counter, write log, read statistics.
  int          cyc = 0;
  int          wr_cnt = 0;
  logic [27:0] wr_din [16];
  int          wr_edge[16];
  int          rd_cnt [2] = '{default: 0};
  int          rd0_first = -1;
  int          rd1_first = -1;
  int          overlap = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pel_if.write) begin
      wr_din[wr_cnt[3:0]]  <= pel_if.din;
      wr_edge[wr_cnt[3:0]] <= cyc + 1;
      wr_cnt <= wr_cnt + 1;
    end
    if (pel_if.write && ((|src_if.read) || (|coef_if.read))) overlap <= overlap + 1;
    if (src_if.read[0]) begin
      rd_cnt[0] <= rd_cnt[0] + 1;
      if (rd0_first < 0) rd0_first <= cyc + 1;
    end
    if (src_if.read[1]) begin
      rd_cnt[1] <= rd_cnt[1] + 1;
      if (rd1_first < 0) rd1_first <= cyc + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] exp_din(input logic tag, input int value);
    return {tag, 27'(value)};
  endfunction

  task automatic push_src(input int f, input int s);
    src_mem[f][src_wr[f][3:0]] = SW'(s);
    src_wr[f] = src_wr[f] + 1;
  endtask

  task automatic push_coef(input int f, input int c);
    coef_mem[f][coef_wr[f][3:0]] = CW'(c);
    coef_wr[f] = coef_wr[f] + 1;
  endtask

  task automatic push_pkt(input int f, input int s0, input int s1, input int s2, input int s3,
                          input int c0, input int c1, input int c2, input int c3);
    push_src(f, s0); push_src(f, s1); push_src(f, s2); push_src(f, s3);
    push_coef(f, c0); push_coef(f, c1); push_coef(f, c2); push_coef(f, c3);
  endtask

  task automatic wait_write(input int target, input int budget);
    int k = 0;
    while (wr_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("write_timeout", 64'(wr_cnt >= target), 64'd1);
  endtask

  int t0;
  int base;

  initial begin
    rst_n  = 1'b0;
    full_r = 2'b00;
    repeat (2) @(negedge clk);
    check_eq("rst_write", 64'(pel_if.write), 64'd0);
    check_eq("rst_read", 64'({src_if.read, coef_if.read}), 64'd0);
    check_eq("rst_din", 64'(pel_if.din), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic packet and latency: 12200 + 2048.
    t0 = cyc;
    push_pkt(0, 100, 200, -300, 400, 64, -83, 36, 83);
    wait_write(1, 20);
    check_eq("basic_din", 64'(wr_din[0]), 64'(exp_din(1'b0, 14248)));
    check_eq("basic_write_lat", 64'(wr_edge[0] - t0), 64'd6);
    check_eq("basic_first_read", 64'(rd0_first - t0), 64'd2);
    check_eq("basic_reads", 64'(rd_cnt[0]), 64'd4);

    // Both fluxes ready together: flux 0 finishes before flux 1 is touched.
    push_pkt(0, -32768, -32768, -32768, -32768, -128, -128, -128, -128);
    push_pkt(1, 1, 2, 3, 4, 1, 1, 1, 1);
    wait_write(3, 40);
    check_eq("neg_extreme_din", 64'(wr_din[1]), 64'(exp_din(1'b0, 16779264)));
    check_eq("flux1_din", 64'(wr_din[2]), 64'(exp_din(1'b1, 2058)));
    check_eq("priority_order", 64'(rd1_first > wr_edge[1]), 64'd1);
    check_eq("back_to_back", 64'(wr_edge[2] - wr_edge[1]), 64'd6);

    // Mixed-sign extreme.
    push_pkt(0, -32768, -32768, -32768, -32768, 127, 127, 127, 127);
    wait_write(4, 20);
    check_eq("mixed_extreme_din", 64'(wr_din[3]), 64'(exp_din(1'b0, -16644096)));

    // Coefficient starvation after two pairs for three cycles.
    repeat (2) @(negedge clk);
    base = rd_cnt[0];
    t0 = cyc;
    push_src(0, 100); push_src(0, 200); push_src(0, -300); push_src(0, 400);
    push_coef(0, 64); push_coef(0, -83);
    repeat (6) @(negedge clk);
    check_eq("stall_reads_held", 64'(rd_cnt[0] - base), 64'd2);
    push_coef(0, 36); push_coef(0, 83);
    wait_write(5, 20);
    check_eq("stall_din", 64'(wr_din[4]), 64'(exp_din(1'b0, 14248)));
    check_eq("stall_write_lat", 64'(wr_edge[4] - t0), 64'd9);

    // Output back-pressure for five cycles in OUT.
    repeat (2) @(negedge clk);
    base = rd_cnt[0];
    full_r = 2'b01;
    t0 = cyc;
    push_pkt(0, 100, 200, -300, 400, 64, -83, 36, 83);
    repeat (10) @(negedge clk);
    check_eq("full_no_write_cnt", 64'(wr_cnt), 64'd5);
    check_eq("full_write_low", 64'(pel_if.write), 64'd0);
    check_eq("full_din_held", 64'(pel_if.din), 64'(exp_din(1'b0, 14248)));
    check_eq("full_no_extra_reads", 64'(rd_cnt[0] - base), 64'd4);
    full_r = 2'b00;
    wait_write(6, 10);
    check_eq("full_release_lat", 64'(wr_edge[5] - t0), 64'd11);
    check_eq("full_release_din", 64'(wr_din[5]), 64'(exp_din(1'b0, 14248)));

    // Reset after two pairs have been consumed.
    repeat (2) @(negedge clk);
    base = rd_cnt[0];
    push_pkt(0, 1000, 1000, 1000, 1000, 100, 100, 100, 100);
    repeat (3) @(negedge clk);
    check_eq("pre_reset_reads", 64'(rd_cnt[0] - base), 64'd2);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_write", 64'(pel_if.write), 64'd0);
    check_eq("midrst_read", 64'({src_if.read, coef_if.read}), 64'd0);
    check_eq("midrst_din", 64'(pel_if.din), 64'd0);
    src_wr[0]  = src_rd[0];
    coef_wr[0] = coef_rd[0];
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midrst_no_write", 64'(wr_cnt), 64'd6);
    push_pkt(0, 100, 200, -300, 400, 64, -83, 36, 83);
    wait_write(7, 20);
    check_eq("post_reset_din", 64'(wr_din[6]), 64'(exp_din(1'b0, 14248)));

    check_eq("no_read_write_overlap", 64'(overlap), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
